// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package prefetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrop
   } state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/prefetch_if.sv
// Instruction-memory, redirect and decode-side signals of the prefetch stage.
interface prefetch_if #(
   parameter int unsigned DEPTH = 4
) ();

   logic                     imem_req;
   logic [31:0]              imem_addr;
   logic                     imem_ack;
   logic [31:0]              imem_rdata;
   logic                     redirect;
   logic [31:0]              redirect_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_inst;
   logic [31:0]              out_pc;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output imem_req, imem_addr, out_valid, out_inst, out_pc, count,
      input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_inst, out_pc, count,
      output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
   );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of {inst, pc} entries with flush; DEPTH must be a power of two.
module prefetch_fifo
   import prefetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wdata,
   output entry_t                 rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   entry_t            mem [DEPTH];
   logic   [AW-1:0]   wptr;
   logic   [AW-1:0]   rptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign empty = (count == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: one outstanding imem request, FIFO toward decode, redirect flush.
// Optional same-cycle ack-to-decode bypass is enabled by defining PREFETCH_BYPASS_EN.
module prefetch_unit
   import prefetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic        clk,
   input logic        rst,
   prefetch_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t          state;
   logic   [31:0]   fetch_pc;
   logic   [31:0]   inflight_pc;
   entry_t          head;
   entry_t          wentry;
   logic            fifo_empty;
   logic   [CW-1:0] fifo_count;
   logic   [CW-1:0] post_occ;
   logic            ack_ok;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            req_ok;

   assign ack_ok = (state == StWait) && bus.imem_ack && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
   assign bypass = ack_ok && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign pop      = !fifo_empty && bus.out_ready && !bus.redirect;
   assign push     = ack_ok && !(bypass && bus.out_ready);
   assign post_occ = fifo_count + CW'(push) - CW'(pop);

   // A free slot must remain after this cycle so the next word can always land.
   assign req_ok = !bus.redirect
                   && ((state == StIdle) || ((state == StWait) && bus.imem_ack))
                   && (post_occ < CW'(DEPTH));

   assign bus.imem_req  = rst && req_ok;
   assign bus.imem_addr = fetch_pc;
   assign bus.count     = fifo_count;
   assign wentry        = '{inst: bus.imem_rdata, pc: inflight_pc};

   // fetch_pc already points at the next word, so back-to-back requests need no adder on the bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         fetch_pc    <= RESET_PC;
         inflight_pc <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc <= bus.redirect_pc;
         state    <= ((state != StIdle) && !bus.imem_ack) ? StDrop : StIdle;
      end else if (req_ok) begin
         fetch_pc    <= fetch_pc + 32'd4;
         inflight_pc <= fetch_pc;
         state       <= StWait;
      end else begin
         unique case (state)
            StWait:  if (bus.imem_ack) state <= StIdle;
            StDrop:  if (bus.imem_ack) state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.out_valid = !fifo_empty || bypass;
      bus.out_inst  = '0;
      bus.out_pc    = '0;
      if (!fifo_empty) begin
         bus.out_inst = head.inst;
         bus.out_pc   = head.pc;
      end else if (bypass) begin
         bus.out_inst = bus.imem_rdata;
         bus.out_pc   = inflight_pc;
      end
   end

   prefetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .wdata (wentry),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a latency-configurable imem responder and output scoreboard.
module tb_prefetch_unit;
   import prefetch_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   prefetch_if #(.DEPTH(DEPTH)) bus ();

   prefetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          lat   = 1;
   entry_t      exp_q [$];
   logic        pend  = 1'b0;
   logic        stale = 1'b0;
   int          pcnt  = 0;
   logic [31:0] paddr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h200) return 32'h0050_0113;
      return {a[15:0], 16'h0013} ^ 32'h1234_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // imem responder plus reference model: drives acks, tracks discards, scores decode output.
   initial begin
      entry_t e;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_ack = 1'b0;
         if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_word(paddr);
               pend           = 1'b0;
            end
         end
         @(negedge clk);
         if (bus.imem_ack) begin
            if (!bus.redirect && !stale) exp_q.push_back('{inst: bus.imem_rdata, pc: paddr});
            stale = 1'b0;
         end
         if (bus.redirect) begin
            exp_q.delete();
            if (pend) stale = 1'b1;
         end
         if (bus.imem_req) begin
            pend  = 1'b1;
            paddr = bus.imem_addr;
            pcnt  = lat;
            stale = 1'b0;
         end
         if (bus.out_valid && bus.out_ready && !bus.redirect) begin
            tests++;
            assert (exp_q.size() != 0)
            else begin
               fails++;
               $error("FAIL sb_underflow: observed pc %h with empty expected queue", bus.out_pc);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_pc", bus.out_pc, e.pc);
               check("sb_inst", bus.out_inst, e.inst);
            end
         end else if (!bus.out_valid) begin
            check("idle_inst_zero", bus.out_inst, 32'h0);
            check("idle_pc_zero", bus.out_pc, 32'h0);
         end
      end
   end

   initial begin
      int n;
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      // Reset values with no clock edge yet.
      #2;
      check("rst_req", 32'(bus.imem_req), 32'h0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_inst", bus.out_inst, 32'h0);
      check("rst_pc", bus.out_pc, 32'h0);
      check("rst_count", 32'(bus.count), 32'h0);
      repeat (3) @(negedge clk);
      check("rst_req_held", 32'(bus.imem_req), 32'h0);

      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("first_req", 32'(bus.imem_req), 32'h1);
      check("first_addr", bus.imem_addr, 32'h0);

      // Backpressure fills the FIFO and stops requests.
      repeat (12) @(negedge clk);
      check("full_count", 32'(bus.count), 32'd4);
      check("full_no_req", 32'(bus.imem_req), 32'h0);
      check("full_head_pc", bus.out_pc, 32'h0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("resume_req", 32'(bus.imem_req), 32'h1);
      check("resume_addr", bus.imem_addr, 32'h10);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("stream_valid", 32'(bus.out_valid), 32'h1);
      end

      // Redirect while a slow request is outstanding.
      @(posedge clk); #1;
      lat = 3;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.imem_req && n < 10);
      check("slow_req_seen", 32'(bus.imem_req), 32'h1);
      @(posedge clk); #1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h40;
      lat             = 1;
      @(negedge clk);
      check("redir_no_req", 32'(bus.imem_req), 32'h0);
      @(posedge clk); #1;
      bus.redirect = 1'b0;
      @(negedge clk);
      check("redir_valid", 32'(bus.out_valid), 32'h0);
      check("redir_count", 32'(bus.count), 32'h0);
      check("drop_no_req", 32'(bus.imem_req), 32'h0);
      @(negedge clk);
      check("stale_ack", 32'(bus.imem_ack), 32'h1);
      check("stale_no_req", 32'(bus.imem_req), 32'h0);
      check("stale_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      check("refetch_req", 32'(bus.imem_req), 32'h1);
      check("refetch_addr", bus.imem_addr, 32'h40);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("refetch_valid", 32'(bus.out_valid), 32'h1);
      check("refetch_pc", bus.out_pc, 32'h40);

      // Redirect coincident with an ack while two entries are buffered.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      lat           = 2;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.imem_req && (int'(bus.count) + int'(bus.imem_ack) == 2)) && n < 30);
      check("coinc_setup", 32'(bus.imem_req), 32'h1);
      @(posedge clk);
      @(posedge clk); #1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      @(negedge clk);
      check("coinc_ack", 32'(bus.imem_ack), 32'h1);
      check("coinc_count_before", 32'(bus.count), 32'd2);
      check("coinc_no_req", 32'(bus.imem_req), 32'h0);
      @(posedge clk); #1;
      bus.redirect  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("coinc_valid", 32'(bus.out_valid), 32'h0);
      check("coinc_count", 32'(bus.count), 32'h0);
      check("coinc_req", 32'(bus.imem_req), 32'h1);
      check("coinc_addr", bus.imem_addr, 32'h200);

      // Ack into an empty FIFO: same-cycle with bypass, next cycle without.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.imem_ack && n < 10);
      check("empty_ack_seen", 32'(bus.imem_ack), 32'h1);
`ifdef PREFETCH_BYPASS_EN
      check("byp_valid", 32'(bus.out_valid), 32'h1);
      check("byp_inst", bus.out_inst, 32'h0050_0113);
      check("byp_pc", bus.out_pc, 32'h200);
      check("byp_count", 32'(bus.count), 32'h0);
      @(negedge clk);
      check("byp_count_after", 32'(bus.count), 32'h0);
`else
      check("nobyp_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      check("nobyp_valid_next", 32'(bus.out_valid), 32'h1);
      check("nobyp_inst", bus.out_inst, 32'h0050_0113);
      check("nobyp_pc", bus.out_pc, 32'h200);
`endif

      repeat (6) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
